// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state encoding, key indices and digit type for the keypad path.
// NUMBER_ACCUMULATOR_BACKSPACE_EN adds the backspace key as index 10.
package keypad_pkg;
    typedef enum logic [1:0] {IDLE, DEBOUNCE, COMMIT, RELEASE} acc_state_t;
    typedef logic [3:0] digit_t;
    localparam int KEY_ZERO  = 0;
    localparam int KEY_ONE   = 1;
    localparam int KEY_TWO   = 2;
    localparam int KEY_THREE = 3;
    localparam int KEY_FOUR  = 4;
    localparam int KEY_FIVE  = 5;
    localparam int KEY_SIX   = 6;
    localparam int KEY_SEVEN = 7;
    localparam int KEY_EIGHT = 8;
    localparam int KEY_NINE  = 9;
`ifdef NUMBER_ACCUMULATOR_BACKSPACE_EN
    localparam int KEY_BACKSPACE = 10;
    localparam int KEY_COUNT     = 11;
`else
    localparam int KEY_COUNT     = 10;
`endif
    // True when exactly one key line is set.
    function automatic logic is_one_hot(input logic [KEY_COUNT-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction
    // Index of the set key; only meaningful for a one-hot vector.
    function automatic digit_t key_index(input logic [KEY_COUNT-1:0] v);
        digit_t idx;
        idx = '0;
        for (int i = 0; i < KEY_COUNT; i++)
            if (v[i]) idx = digit_t'(i);
        return idx;
    endfunction
endpackage

// File: rtl/key_sync.sv
// key_sync: WIDTH-bit two-flop synchroniser for raw asynchronous key lines.
module key_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);
    logic [WIDTH-1:0] r_meta;
    // Two flops in series give metastability time before the lines are used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            o_sync <= '0;
        end else begin
            r_meta <= i_async;
            o_sync <= r_meta;
        end
    end
endmodule

// File: rtl/number_accumulator.sv
// number_accumulator: debounces keypad presses and latches digit_selector's result once per press.
// Clear key resets the value and sticky overflow; NUMBER_ACCUMULATOR_BACKSPACE_EN adds a backspace key.
module number_accumulator
    import keypad_pkg::*;
#(
    parameter int NUMBER_WIDTH    = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    zero,
    input  logic                    one,
    input  logic                    two,
    input  logic                    three,
    input  logic                    four,
    input  logic                    five,
    input  logic                    six,
    input  logic                    seven,
    input  logic                    eight,
    input  logic                    nine,
    input  logic                    clear,
`ifdef NUMBER_ACCUMULATOR_BACKSPACE_EN
    input  logic                    backspace,
`endif
    input  logic [NUMBER_WIDTH-1:0] new_number,
    output logic [NUMBER_WIDTH-1:0] previous_number,
    output logic                    commit,
    output logic                    overflow
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    typedef logic [NUMBER_WIDTH+3:0] cand_t;

    logic [KEY_COUNT:0]   w_raw;
    logic [KEY_COUNT:0]   w_sync;
    logic [KEY_COUNT-1:0] w_key_vec;
    logic                 w_clear;
    logic                 w_one_hot;
    digit_t               w_digit;
    cand_t                w_cand;
    logic                 w_ovf;

    acc_state_t           r_state;
    logic [KEY_COUNT-1:0] r_cap_vec;
    logic [KEY_COUNT-1:0] r_prev_vec;
    logic [CW-1:0]        r_cnt;

`ifdef NUMBER_ACCUMULATOR_BACKSPACE_EN
    assign w_raw = {clear, backspace, nine, eight, seven, six, five, four, three, two, one, zero};
`else
    assign w_raw = {clear, nine, eight, seven, six, five, four, three, two, one, zero};
`endif

    key_sync #(.WIDTH(KEY_COUNT + 1)) u_key_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (w_raw),
        .o_sync  (w_sync)
    );

    assign w_key_vec = w_sync[KEY_COUNT-1:0];
    assign w_clear   = w_sync[KEY_COUNT];
    assign w_one_hot = is_one_hot(w_key_vec);
    // The captured vector is stable through COMMIT even if the lines move.
    assign w_digit   = key_index(r_cap_vec);
    assign w_cand    = cand_t'(previous_number) * cand_t'(10) + cand_t'(w_digit);
    assign w_ovf     = w_cand[NUMBER_WIDTH+3:NUMBER_WIDTH] != 4'b0;

    // Press FSM: a press is only new if the previous sample was all-released,
    // so a multi-key chord collapsing to one key never commits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_cap_vec       <= '0;
            r_prev_vec      <= '0;
            r_cnt           <= '0;
            previous_number <= '0;
            commit          <= 1'b0;
            overflow        <= 1'b0;
        end else begin
            r_prev_vec <= w_key_vec;
            commit     <= 1'b0;
            if (w_clear) begin
                previous_number <= '0;
                overflow        <= 1'b0;
                r_cnt           <= '0;
                r_state         <= RELEASE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_one_hot && r_prev_vec == '0) begin
                            r_cap_vec <= w_key_vec;
                            r_cnt     <= CW'(1);
                            r_state   <= (DEBOUNCE_CYCLES == 1) ? COMMIT : DEBOUNCE;
                        end
                    end
                    DEBOUNCE: begin
                        if (w_key_vec == r_cap_vec) begin
                            r_cnt <= r_cnt + 1'b1;
                            if (r_cnt + 1'b1 == CW'(DEBOUNCE_CYCLES)) r_state <= COMMIT;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    COMMIT: begin
                        r_cnt   <= '0;
                        r_state <= RELEASE;
`ifdef NUMBER_ACCUMULATOR_BACKSPACE_EN
                        if (r_cap_vec[KEY_BACKSPACE]) begin
                            previous_number <= previous_number / NUMBER_WIDTH'(10);
                            commit          <= 1'b1;
                        end else
`endif
                        if (w_ovf) begin
                            overflow <= 1'b1;
                        end else begin
                            previous_number <= new_number;
                            commit          <= 1'b1;
                        end
                    end
                    RELEASE: begin
                        if (w_key_vec != '0) begin
                            r_cnt <= '0;
                        end else if (r_cnt + 1'b1 == CW'(DEBOUNCE_CYCLES)) begin
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule
